// File: rtl/internal_bus_arbiter_pkg.sv
// Shared types and constants for the two-master internal bus arbiter.
// Holds the one-hot FSM state encoding, word width and default watchdog data.
package internal_bus_arbiter_pkg;

   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] DEF_TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      IDLE     = 3'b001,
      GRANT_WR = 3'b010,
      GRANT_RD = 3'b100
   } state_t;

endpackage

// File: rtl/internal_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: one-hot grant from a 2-bit request vector.
// Ports: req[1:0] requests, last = index of the master granted last,
// grant[1:0] one-hot winner (00 when nobody requests).
module rr_pick2
   import internal_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // tie goes to the master that was not served last
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/internal_bus_arbiter.sv
// Two-master to one-slave bus arbiter with round-robin ties, write-over-read
// priority per master, burst locking and an optional grant watchdog.
// Ports: clk, reset (sync, active high); m0_/m1_ addr, write_data,
// write_valid, write_ready, read_req, read_data, read_valid; slave side
// s_addr, s_write_data, s_write_valid, s_read_req, s_write_ready,
// s_read_valid, s_read_data; o_grant one-hot owner; o_timeout_err sticky
// watchdog flag cleared by i_timeout_clr.
// Macro ARB_TIMEOUT_EN builds the watchdog; otherwise grants wait forever.
module internal_bus_arbiter
   import internal_bus_arbiter_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = 1024,
   parameter logic [WORD_W-1:0] TIMEOUT_DATA   = DEF_TIMEOUT_DATA
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] m0_addr,
   input  logic [WORD_W-1:0] m0_write_data,
   input  logic              m0_write_valid,
   output logic              m0_write_ready,
   input  logic              m0_read_req,
   output logic [WORD_W-1:0] m0_read_data,
   output logic              m0_read_valid,
   input  logic [WORD_W-1:0] m1_addr,
   input  logic [WORD_W-1:0] m1_write_data,
   input  logic              m1_write_valid,
   output logic              m1_write_ready,
   input  logic              m1_read_req,
   output logic [WORD_W-1:0] m1_read_data,
   output logic              m1_read_valid,
   output logic [WORD_W-1:0] s_addr,
   output logic [WORD_W-1:0] s_write_data,
   output logic              s_write_valid,
   output logic              s_read_req,
   input  logic              s_write_ready,
   input  logic              s_read_valid,
   input  logic [WORD_W-1:0] s_read_data,
   output logic [1:0]        o_grant,
   output logic              o_timeout_err,
   input  logic              i_timeout_clr
);

   state_t            state;
   logic              owner;
   logic              last;
   logic [1:0]        grant_q;
   logic [1:0]        wv;
   logic [1:0]        rq;
   logic [1:0]        pick;
   logic              active;
   logic              fire;
   logic [WORD_W-1:0] sel_addr;
   logic [WORD_W-1:0] sel_wdata;
   logic [WORD_W-1:0] rdata;

   assign wv        = {m1_write_valid, m0_write_valid};
   assign rq        = {m1_read_req, m0_read_req};
   assign sel_addr  = owner ? m1_addr : m0_addr;
   assign sel_wdata = owner ? m1_write_data : m0_write_data;

   rr_pick2 u_pick (
      .req   (wv | rq),
      .last  (last),
      .grant (pick)
   );

   // the granted request line for the granted type keeps the bus locked
   assign active = (state == GRANT_WR && wv[owner]) ||
                   (state == GRANT_RD && rq[owner]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         owner   <= 1'b0;
         last    <= 1'b1;
         grant_q <= 2'b00;
      end else begin
         unique case (state)
            IDLE: begin
               if (|pick) begin
                  owner   <= pick[1];
                  grant_q <= pick;
                  state   <= wv[pick[1]] ? GRANT_WR : GRANT_RD;
               end
            end
            GRANT_WR, GRANT_RD: begin
               if (!active) begin
                  state   <= IDLE;
                  grant_q <= 2'b00;
                  last    <= owner;
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   assign o_grant = grant_q;

   always_comb begin
      s_addr         = '0;
      s_write_data   = '0;
      s_write_valid  = 1'b0;
      s_read_req     = 1'b0;
      m0_write_ready = 1'b0;
      m1_write_ready = 1'b0;
      m0_read_valid  = 1'b0;
      m1_read_valid  = 1'b0;
      m0_read_data   = '0;
      m1_read_data   = '0;
      rdata = (fire && !s_read_valid) ? TIMEOUT_DATA : s_read_data;
      unique case (state)
         GRANT_WR: begin
            if (active) begin
               s_addr        = sel_addr;
               s_write_data  = sel_wdata;
               s_write_valid = 1'b1;
            end
            // responses pass even in the release cycle
            m0_write_ready = !owner && (s_write_ready || fire);
            m1_write_ready =  owner && (s_write_ready || fire);
         end
         GRANT_RD: begin
            if (active) begin
               s_addr     = sel_addr;
               s_read_req = 1'b1;
            end
            m0_read_valid = !owner && (s_read_valid || fire);
            m1_read_valid =  owner && (s_read_valid || fire);
            m0_read_data  = owner ? '0 : rdata;
            m1_read_data  = owner ? rdata : '0;
         end
         default: ;
      endcase
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;
   logic          err;
   logic          hs;

   assign hs = (state == GRANT_WR && s_write_ready) ||
               (state == GRANT_RD && s_read_valid);

   // cnt holds idle cycles already spent, so the last allowed one fires
   assign fire = active && !hs &&
                 (cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (state == IDLE || hs || fire)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
         if (fire)
            err <= 1'b1;
         else if (i_timeout_clr)
            err <= 1'b0;
      end
   end

   assign o_timeout_err = err;
`else
   logic unused;

   assign fire          = 1'b0;
   assign o_timeout_err = 1'b0;
   assign unused        = i_timeout_clr ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_internal_bus_arbiter.sv
// Scoreboard bench for internal_bus_arbiter: master models, a reactive
// slave, and per-scenario tasks checking grants and beat ordering.
module tb_internal_bus_arbiter;

   localparam logic [31:0] RKEY = 32'h5A5A_0F0F;

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m0_addr, m0_write_data, m1_addr, m1_write_data;
   logic        m0_write_valid, m0_read_req;
   logic        m1_write_valid, m1_read_req;
   logic        m0_write_ready, m1_write_ready;
   logic        m0_read_valid, m1_read_valid;
   logic [31:0] m0_read_data, m1_read_data;
   logic [31:0] s_addr, s_write_data, s_read_data;
   logic        s_write_valid, s_read_req;
   logic        s_write_ready, s_read_valid;
   logic [1:0]  o_grant;
   logic        o_timeout_err;
   logic        i_timeout_clr;
   logic        slave_on;

   beat_t       wr_q[$];
   beat_t       rd_q[$];
   beat_t       e;
   int          errors = 0;
   int          checks = 0;
   int          wr_left[2];
   int          rd_left[2];
   logic [31:0] wr_addr[2];
   logic [31:0] rd_addr[2];
   logic        acc_w[2];
   logic        acc_r[2];

   always #5 clk = ~clk;

   assign s_write_ready = slave_on;
   assign s_read_valid  = slave_on & s_read_req;
   assign s_read_data   = s_read_req ? (s_addr ^ RKEY) : 32'h0;

   internal_bus_arbiter #(
      .TIMEOUT_CYCLES (8),
      .TIMEOUT_DATA   (32'hDEAD_BEEF)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .m0_addr        (m0_addr),
      .m0_write_data  (m0_write_data),
      .m0_write_valid (m0_write_valid),
      .m0_write_ready (m0_write_ready),
      .m0_read_req    (m0_read_req),
      .m0_read_data   (m0_read_data),
      .m0_read_valid  (m0_read_valid),
      .m1_addr        (m1_addr),
      .m1_write_data  (m1_write_data),
      .m1_write_valid (m1_write_valid),
      .m1_write_ready (m1_write_ready),
      .m1_read_req    (m1_read_req),
      .m1_read_data   (m1_read_data),
      .m1_read_valid  (m1_read_valid),
      .s_addr         (s_addr),
      .s_write_data   (s_write_data),
      .s_write_valid  (s_write_valid),
      .s_read_req     (s_read_req),
      .s_write_ready  (s_write_ready),
      .s_read_valid   (s_read_valid),
      .s_read_data    (s_read_data),
      .o_grant        (o_grant),
      .o_timeout_err  (o_timeout_err),
      .i_timeout_clr  (i_timeout_clr)
   );

   function automatic logic [31:0] wd(input int n, input logic [31:0] a);
      return a ^ ((n == 1) ? 32'h1111_0000 : 32'h2222_0000);
   endfunction

   task automatic start_wr(input int n, input logic [31:0] base,
                           input int beats);
      for (int b = 0; b < beats; b++) begin
         e.m    = n;
         e.addr = base + 32'(4 * b);
         e.data = wd(n, e.addr);
         wr_q.push_back(e);
      end
      wr_addr[n] = base;
      wr_left[n] = beats;
   endtask

   task automatic start_rd(input int n, input logic [31:0] base,
                           input int beats);
      for (int b = 0; b < beats; b++) begin
         e.m    = n;
         e.addr = base + 32'(4 * b);
         e.data = e.addr ^ RKEY;
         rd_q.push_back(e);
      end
      rd_addr[n] = base;
      rd_left[n] = beats;
   endtask

   // master models: hold request levels until every beat is accepted
   initial begin
      for (int n = 0; n < 2; n++) begin
         wr_left[n] = 0;
         rd_left[n] = 0;
         wr_addr[n] = '0;
         rd_addr[n] = '0;
         acc_w[n]   = 1'b0;
         acc_r[n]   = 1'b0;
      end
      m0_addr = '0; m0_write_data = '0;
      m1_addr = '0; m1_write_data = '0;
      m0_write_valid = 1'b0; m0_read_req = 1'b0;
      m1_write_valid = 1'b0; m1_read_req = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         for (int n = 0; n < 2; n++) begin
            if (acc_w[n]) begin
               wr_left[n]--;
               wr_addr[n] += 32'd4;
            end
            if (acc_r[n]) begin
               rd_left[n]--;
               rd_addr[n] += 32'd4;
            end
            acc_w[n] = 1'b0;
            acc_r[n] = 1'b0;
         end
         m0_write_valid = wr_left[0] > 0;
         m0_read_req    = rd_left[0] > 0;
         m0_addr        = (wr_left[0] > 0) ? wr_addr[0] : rd_addr[0];
         m0_write_data  = wd(0, wr_addr[0]);
         m1_write_valid = wr_left[1] > 0;
         m1_read_req    = rd_left[1] > 0;
         m1_addr        = (wr_left[1] > 0) ? wr_addr[1] : rd_addr[1];
         m1_write_data  = wd(1, wr_addr[1]);
      end
   end

   // scoreboard: pops expected beats as the DUT completes them
   initial forever begin
      logic [1:0]  rv;
      logic [1:0]  wr;
      logic [31:0] rdat[2];
      logic [1:0]  eg;
      @(negedge clk);
      rv = {m1_read_valid, m0_read_valid};
      wr = {m1_write_ready, m0_write_ready};
      rdat[0] = m0_read_data;
      rdat[1] = m1_read_data;
      acc_w[0] = m0_write_valid && m0_write_ready;
      acc_w[1] = m1_write_valid && m1_write_ready;
      acc_r[0] = m0_read_req && m0_read_valid;
      acc_r[1] = m1_read_req && m1_read_valid;
      if (!reset) begin
         if (s_write_valid && s_write_ready) begin
            checks++;
            if (wr_q.size() == 0) begin
               errors++;
               $display("FAIL wr_beat: unexpected addr=%h", s_addr);
            end else begin
               e  = wr_q.pop_front();
               eg = (e.m == 1) ? 2'b10 : 2'b01;
               if (o_grant !== eg || s_addr !== e.addr ||
                   s_write_data !== e.data) begin
                  errors++;
                  $display("FAIL wr_beat: got g=%b a=%h d=%h need g=%b a=%h d=%h",
                           o_grant, s_addr, s_write_data,
                           eg, e.addr, e.data);
               end
            end
         end
         for (int n = 0; n < 2; n++) begin
            if (rv[n]) begin
               checks++;
               if (rd_q.size() == 0) begin
                  errors++;
                  $display("FAIL rd_beat: unexpected m%0d data=%h",
                           n, rdat[n]);
               end else begin
                  e = rd_q.pop_front();
                  if (e.m != n || rdat[n] !== e.data) begin
                     errors++;
                     $display("FAIL rd_beat: got m%0d d=%h need m%0d d=%h",
                              n, rdat[n], e.m, e.data);
                  end
               end
            end
            checks++;
            if (!o_grant[n] && (wr[n] || rv[n] || rdat[n] !== 32'h0)) begin
               errors++;
               $display("FAIL idle_master: m%0d got rdy=%b vld=%b d=%h need 0",
                        n, wr[n], rv[n], rdat[n]);
            end
         end
      end
   end

   task automatic wait_done();
      int cyc = 0;
      while ((wr_q.size() != 0 || rd_q.size() != 0 ||
              wr_left[0] != 0 || wr_left[1] != 0 ||
              rd_left[0] != 0 || rd_left[1] != 0) && cyc < 200) begin
         @(posedge clk);
         #2;
         cyc++;
      end
      checks++;
      if (cyc >= 200) begin
         errors++;
         $display("FAIL drain: got wq=%0d rq=%0d pending, need 0",
                  wr_q.size(), rd_q.size());
      end
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (o_grant !== 2'b00) begin
         errors++;
         $display("FAIL reset_grant: got %b need 00", o_grant);
      end
      checks++;
      if ({s_write_valid, s_read_req, m0_write_ready, m1_write_ready,
           m0_read_valid, m1_read_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b need 000000",
                  {s_write_valid, s_read_req, m0_write_ready,
                   m1_write_ready, m0_read_valid, m1_read_valid});
      end
      checks++;
      if ((s_addr | s_write_data | m0_read_data | m1_read_data) !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got a=%h w=%h r0=%h r1=%h need 0",
                  s_addr, s_write_data, m0_read_data, m1_read_data);
      end
      checks++;
      if (o_timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: got %b need 0", o_timeout_err);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_tie_after_reset();
      logic [1:0] exp [9] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00,
                              2'b10, 2'b10, 2'b10, 2'b00};
      @(negedge clk);
      #1;
      start_rd(0, 32'h0000_2000, 2);
      start_rd(1, 32'h0000_2100, 2);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         checks++;
         if (o_grant !== exp[i]) begin
            errors++;
            $display("FAIL tie_grant[%0d]: got %b need %b",
                     i, o_grant, exp[i]);
         end
      end
      wait_done();
   endtask

   task automatic test_write_burst();
      logic [1:0] exp [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
      @(negedge clk);
      #1;
      start_wr(0, 32'h0000_1000, 3);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (o_grant !== exp[i]) begin
            errors++;
            $display("FAIL wrburst_grant[%0d]: got %b need %b",
                     i, o_grant, exp[i]);
         end
      end
      wait_done();
   endtask

   task automatic test_contention();
      int cyc = 0;
      @(negedge clk);
      #1;
      start_wr(0, 32'h0000_6000, 3);
      repeat (2) @(negedge clk);
      #1;
      start_wr(1, 32'h0000_7000, 2);
      while (m0_write_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc >= 50) begin
         errors++;
         $display("FAIL m0_release: got valid=%b need 0", m0_write_valid);
      end
      #1;
      start_wr(0, 32'h0000_6100, 1);
      wait_done();
   endtask

   task automatic test_wr_priority();
      logic [1:0] exp [9] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00,
                              2'b01, 2'b01, 2'b01, 2'b00};
      logic       erq [9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
      @(negedge clk);
      #1;
      start_wr(0, 32'h0000_8000, 2);
      start_rd(0, 32'h0000_9000, 2);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         checks++;
         if (o_grant !== exp[i] || s_read_req !== erq[i]) begin
            errors++;
            $display("FAIL wrprio[%0d]: got g=%b rq=%b need g=%b rq=%b",
                     i, o_grant, s_read_req, exp[i], erq[i]);
         end
      end
      wait_done();
   endtask

   task automatic test_reset_mid_burst();
      int cyc = 0;
      @(negedge clk);
      #1;
      start_wr(0, 32'h0000_4000, 5);
      @(negedge clk);
      #1;
      start_wr(1, 32'h0000_5000, 2);
      while (wr_left[0] != 3 && cyc < 50) begin
         @(posedge clk);
         #2;
         cyc++;
      end
      slave_on = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      slave_on = 1'b1;
      @(negedge clk);
      checks++;
      if (o_grant !== 2'b00 || s_write_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_abort: got g=%b wv=%b need g=00 wv=0",
                  o_grant, s_write_valid);
      end
      @(negedge clk);
      checks++;
      if (o_grant !== 2'b01) begin
         errors++;
         $display("FAIL rst_rearb: got %b need 01", o_grant);
      end
      wait_done();
   endtask

   task automatic test_timeout();
      @(negedge clk);
      #1;
      slave_on   = 1'b0;
      rd_addr[1] = 32'h0000_3000;
`ifdef ARB_TIMEOUT_EN
      e.m    = 1;
      e.addr = 32'h0000_3000;
      e.data = 32'hDEAD_BEEF;
      rd_q.push_back(e);
      rd_left[1] = 1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         checks++;
         if (o_grant !== ((i == 0) ? 2'b00 : 2'b10) ||
             m1_read_valid !== (i == 8)) begin
            errors++;
            $display("FAIL wdog[%0d]: got g=%b rv=%b need rv=%b",
                     i, o_grant, m1_read_valid, (i == 8));
         end
      end
      @(negedge clk);
      checks++;
      if (o_timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL wdog_set: got %b need 1", o_timeout_err);
      end
      #1;
      i_timeout_clr = 1'b1;
      @(posedge clk);
      #1;
      i_timeout_clr = 1'b0;
      @(negedge clk);
      checks++;
      if (o_timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL wdog_clr: got %b need 0", o_timeout_err);
      end
      #1;
      slave_on = 1'b1;
`else
      rd_left[1] = 1;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         checks++;
         if (o_grant !== ((i == 0) ? 2'b00 : 2'b10) ||
             m1_read_valid !== 1'b0 || o_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL nowdog[%0d]: got g=%b rv=%b err=%b need rv=0 err=0",
                     i, o_grant, m1_read_valid, o_timeout_err);
         end
      end
      #1;
      e.m    = 1;
      e.addr = 32'h0000_3000;
      e.data = 32'h0000_3000 ^ RKEY;
      rd_q.push_back(e);
      slave_on = 1'b1;
`endif
      wait_done();
   endtask

   initial begin
      reset         = 1'b1;
      slave_on      = 1'b1;
      i_timeout_clr = 1'b0;
      test_reset();
      test_tie_after_reset();
      test_write_burst();
      test_contention();
      test_wr_priority();
      test_reset_mid_burst();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
